// File: rtl/skinny_sched_pkg.sv
// Shared constants, state encoding and randomness-word field positions for the
// SKINNY-64 masked SubCells scheduler.
package skinny_sched_pkg;

  localparam int NUM_CELLS = 16;
  localparam int SBOX_LAT  = 4;
  localparam int IDX_W     = 4;

  localparam int R_LSB  = 0;
  localparam int R_MSB  = 23;
  localparam int RC_LSB = 24;
  localparam int RC_MSB = 31;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/skinny_occ_pipe.sv
// Valid/index shadow of the masked Sbox pipeline; the last stage marks the
// cell leaving the Sbox this cycle.
module skinny_occ_pipe
  import skinny_sched_pkg::*;
#(
  parameter int LAT = SBOX_LAT,
  parameter int IW  = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [IW-1:0] idx_i,
  output logic [LAT-1:0] occ_o,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [LAT-1:0] valid_q;
  logic [IW-1:0]  idx_q [LAT];

  // Bubbles carry a zero index so wr_idx reads 0 whenever wr_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= valid_i ? idx_i : '0;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign occ_o   = valid_q;
  assign valid_o = valid_q[LAT-1];
  assign idx_o   = idx_q[LAT-1];

endmodule

// File: rtl/skinny_sbox_sched.sv
// Issues the cells of one masked SubCells pass into a shared pipelined Sbox,
// tracks them to write-back and gates the PRNG stream onto the Sbox buses.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one cell per cycle with fresh randomness, bubble otherwise
// DRAIN | all cells issued, waiting for the last write-back
// DONE  | one-cycle completion pulse
module skinny_sbox_sched
  import skinny_sched_pkg::*;
#(
  parameter int NUM_CELLS = skinny_sched_pkg::NUM_CELLS,
  parameter int SBOX_LAT  = skinny_sched_pkg::SBOX_LAT,
  parameter int IDX_W     = skinny_sched_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rd_idx,
  output logic             issue,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_req,
  output logic [23:0]      r_out,
  output logic [7:0]       rc_out,
  output logic             rnd_err
);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_CELLS - 1);
  localparam logic [SBOX_LAT-1:0] LAST_ONLY = SBOX_LAT'(1) << (SBOX_LAT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                rnd_err_q, rnd_err_d;
  logic [SBOX_LAT-1:0] occ;
  logic                occ_any;

  assign occ_any = |occ;

  skinny_occ_pipe #(
    .LAT (SBOX_LAT),
    .IW  (IDX_W)
  ) u_occ_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (issue),
    .idx_i   (rd_idx),
    .occ_o   (occ),
    .valid_o (wr_en),
    .idx_o   (wr_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rnd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rnd_err_q <= rnd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rnd_err_d = rnd_err_q;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          cnt_d     = '0;
          rnd_err_d = 1'b0;
        end
      end
      ISSUE: begin
        // The counter wraps back to zero on the last issue, ready for the next pass.
        if (rnd_valid) begin
          issue = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The youngest cell reaching the last stage means every write-back is out.
        if (occ == '0 || occ == LAST_ONLY) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (occ_any && !rnd_valid) rnd_err_d = 1'b1;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_idx  = cnt_q;
  assign rnd_err = rnd_err_q;
  assign rnd_req = ((state_q == ISSUE) || occ_any) && rnd_valid;
  assign r_out   = rnd_req ? rnd_in[R_MSB:R_LSB]   : '0;
  assign rc_out  = rnd_req ? rnd_in[RC_MSB:RC_LSB] : '0;

endmodule

// File: tb/tb_skinny_sbox_sched.sv
// Self-checking bench: randomness slicing table, scoreboarded full passes,
// start filtering, mid-pass reset and a reduced 4-cell / 2-stage instance.
module tb_skinny_sbox_sched;

  localparam int NC  = 16;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic [31:0] rnd_in = '0;
  logic        rnd_valid = 1'b0;

  logic        busy, done, issue, wr_en, rnd_req, rnd_err;
  logic [3:0]  rd_idx, wr_idx;
  logic [23:0] r_out;
  logic [7:0]  rc_out;

  logic        busy_s, done_s, issue_s, wr_en_s, rnd_req_s, rnd_err_s;
  logic [1:0]  rd_idx_s, wr_idx_s;
  logic [23:0] r_out_s;
  logic [7:0]  rc_out_s;

  always #5 clk = ~clk;

  skinny_sbox_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_idx(rd_idx), .issue(issue), .wr_en(wr_en), .wr_idx(wr_idx),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_req(rnd_req),
    .r_out(r_out), .rc_out(rc_out), .rnd_err(rnd_err)
  );

  skinny_sbox_sched #(.NUM_CELLS(4), .SBOX_LAT(2), .IDX_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .rd_idx(rd_idx_s), .issue(issue_s), .wr_en(wr_en_s), .wr_idx(wr_idx_s),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_req(rnd_req_s),
    .r_out(r_out_s), .rc_out(rc_out_s), .rnd_err(rnd_err_s)
  );

  typedef struct {
    logic [31:0] rnd;
    logic [23:0] r;
    logic [7:0]  rc;
  } rnd_vec_t;

  typedef struct {
    int idx;
    int due;
  } exp_t;

  rnd_vec_t vecs [4];
  exp_t     sb_q [$];
  int       n_checks = 0;
  int       n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Entered #1 after a rising edge; returns #1 after a rising edge in IDLE.
  task automatic run_pass(input int bubble_idx, input bit hammer_start);
    int   exp_cnt, done_cyc, k;
    bit   bubbled, err_exp, fin, vld, in_issue, occ, iss_exp, req_exp, wr_exp;
    exp_t e;
    start = 1'b1;
    rnd_valid = 1'b1;
    @(negedge clk);
    check("idle_busy_before_start", busy, 0);
    @(posedge clk); #1;
    start = hammer_start;
    exp_cnt = 0; done_cyc = -1; bubbled = 0; err_exp = 0; fin = 0;
    sb_q.delete();
    for (int c = 1; c <= 60 && !fin; c++) begin
      k = c % 4;
      vld = !(exp_cnt == bubble_idx && !bubbled);
      if (!vld) bubbled = 1;
      rnd_valid = vld;
      rnd_in = vecs[k].rnd;
      @(negedge clk);
      in_issue = exp_cnt < NC;
      occ      = sb_q.size() != 0;
      iss_exp  = in_issue && vld;
      req_exp  = (in_issue || occ) && vld;
      check("busy", busy, 1);
      check("issue", issue, iss_exp);
      check("rnd_req", rnd_req, req_exp);
      check("r_out", r_out, req_exp ? vecs[k].r : 24'h0);
      check("rc_out", rc_out, req_exp ? vecs[k].rc : 8'h0);
      check("rnd_err", rnd_err, err_exp);
      if (iss_exp) begin
        check("rd_idx", rd_idx, exp_cnt);
        sb_q.push_back('{exp_cnt, c + LAT});
        exp_cnt++;
      end
      wr_exp = sb_q.size() != 0 && sb_q[0].due == c;
      check("wr_en", wr_en, wr_exp);
      if (wr_exp) begin
        e = sb_q.pop_front();
        check("wr_idx", wr_idx, e.idx);
        if (exp_cnt == NC && sb_q.size() == 0) done_cyc = c + 1;
      end
      check("done", done, c == done_cyc);
      if (c == done_cyc) fin = 1;
      if (occ && !vld) err_exp = 1;
      @(posedge clk); #1;
    end
    check("pass_completed", fin, 1);
    start = 1'b0;
    @(negedge clk);
    check("idle_busy_after", busy, 0);
    check("idle_done_after", done, 0);
    check("idle_wr_en_after", wr_en, 0);
    check("idle_rnd_req_after", rnd_req, 0);
    check("idle_rnd_err_after", rnd_err, err_exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{32'hA5C3F00F, 24'hC3F00F, 8'hA5};
    vecs[1] = '{32'hFFFFFFFF, 24'hFFFFFF, 8'hFF};
    vecs[2] = '{32'h00000001, 24'h000001, 8'h00};
    vecs[3] = '{32'h12345678, 24'h345678, 8'h12};

    rnd_in = 32'hA5C3F00F;
    rnd_valid = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_issue", issue, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rnd_req", rnd_req, 0);
    check("rst_rnd_err", rnd_err, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_r_out", r_out, 0);
    check("rst_rc_out", rc_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      rnd_in = vecs[i].rnd;
      @(negedge clk);
      check("idle_r_out", r_out, 0);
      check("idle_rc_out", rc_out, 0);
      check("idle_rnd_req", rnd_req, 0);
      @(posedge clk); #1;
    end

    run_pass(-1, 1'b0);
    run_pass(5, 1'b1);
    run_pass(-1, 1'b0);

    // Abort a pass while cells 10..13 occupy the pipeline.
    start = 1'b1;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("pre_abort_wr_en", wr_en, 1);
    check("pre_abort_wr_idx", wr_idx, 10);
    check("pre_abort_rd_idx", rd_idx, 14);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_issue", issue, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_idx", wr_idx, 0);
    check("abort_rd_idx", rd_idx, 0);
    check("abort_rnd_req", rnd_req, 0);
    check("abort_r_out", r_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wr_en || done || busy) bad++;
      @(posedge clk); #1;
    end
    check("post_abort_quiet_cycles", bad, 0);

    // Reduced instance: 4 cells, 2-stage Sbox.
    rnd_valid = 1'b1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("small_issue", issue_s, c <= 4);
      if (c <= 4) check("small_rd_idx", rd_idx_s, c - 1);
      check("small_wr_en", wr_en_s, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) check("small_wr_idx", wr_idx_s, c - 3);
      check("small_done", done_s, c == 7);
      check("small_busy", busy_s, c <= 7);
      @(posedge clk); #1;
    end
    check("small_rnd_err", rnd_err_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_sched.md
Name: skinny_sbox_sched

Overview:
- Sequences one masked SubCells pass of a SKINNY-64 state (16 cells, 3 shares each) through a single shared 4-stage masked Sbox instance.
- Issues one cell index per cycle to the state register file and tracks in-flight cells through the Sbox pipeline.
- Drives the Sbox fresh-randomness (r) and output-remask (rc) buses from an external PRNG stream.
- Generates write-back strobes and indices as cells leave the pipeline. Sits between the round FSM and the Sbox/state-share storage.

Parameters:
- NUM_CELLS, 16, cells per pass (power of two, at least 2).
- SBOX_LAT, 4, cycles from Sbox input to Sbox output.
- IDX_W, 4, cell-index width, equal to log2(NUM_CELLS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the pass is complete.
- rd_idx  out  IDX_W  cell index presented to state storage / Sbox input this cycle.
- issue  out  1  rd_idx is valid and enters the Sbox this cycle.
- wr_en  out  1  Sbox output is valid this cycle.
- wr_idx  out  IDX_W  cell index of the current Sbox output.
- rnd_in  in  32  fresh PRNG word: [23:0] feeds r, [31:24] feeds rc.
- rnd_valid  in  1  rnd_in is fresh this cycle.
- rnd_req  out  1  PRNG word consumed this cycle.
- r_out  out  24  Sbox randomness bus.
- rc_out  out  8  Sbox output-remask bus.
- rnd_err  out  1  sticky flag: a pipeline stage was occupied while rnd_valid was low.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy, done, issue, wr_en, rnd_req, rnd_err are 0.
  - rd_idx, wr_idx are 0.
  - r_out, rc_out are 0.
  - Occupancy shift register is all zero.
- States and transitions:
  - IDLE: start=1 -> ISSUE, issue counter cleared.
  - ISSUE: when rnd_valid=1, issue=1 and rd_idx=counter, then the counter increments. When rnd_valid=0, the cycle is a bubble: issue=0 and the counter holds. After the issue at counter=NUM_CELLS-1 -> DRAIN.
  - DRAIN: waits until the occupancy register is empty and the last wr_en has been seen, then -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- busy is 1 in ISSUE, DRAIN and DONE.
- Pipeline tracking: SBOX_LAT-deep shift register of {valid, idx}. Stage 0 loads {issue, rd_idx}. wr_en and wr_idx are the last stage.
- Latency: a cell issued in cycle t has wr_en=1 with wr_idx equal to that index in cycle t+SBOX_LAT.
- Minimum pass length: NUM_CELLS+SBOX_LAT+1 cycles from the start sample to done.
- Randomness:
  - rnd_req=1 whenever state is ISSUE or any occupancy bit is set, and rnd_valid=1.
  - r_out = rnd_in[23:0] and rc_out = rnd_in[31:24] when rnd_req=1; otherwise both are 0. Zeroing is combinational.
  - If any occupancy bit is set and rnd_valid=0, rnd_err is set. It clears only on reset or on start accepted in IDLE.
  - The pipeline is never stalled: the Sbox has no enable, so in-flight cells keep advancing.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as done is ignored; the next start is accepted only in IDLE.
- Index wrap: the counter is IDX_W bits and never wraps within a pass; exit from ISSUE happens on the last issue.
- Reset mid-pass: all state is cleared asynchronously. No wr_en or done is produced for the aborted pass.

Decomposition:
- Package skinny_sched_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the constants NUM_CELLS, SBOX_LAT, IDX_W;
  - the randomness field slice positions R_LSB=0, R_MSB=23, RC_LSB=24, RC_MSB=31.
- One sub-module: skinny_occ_pipe, the SBOX_LAT-deep valid/index shift register with an async active-low reset.

Test Plan:
- Reset, then start with rnd_valid held at 1 -> issue in cycles 1..16 with rd_idx 0..15; wr_en in cycles 5..20 with wr_idx 0..15; done in cycle 21; rnd_err=0.
- rnd_valid=0 on the cycle rd_idx=5 is due (no cells in flight yet counted as a bubble only) -> idx 5 issues one cycle later; wr_idx sequence still runs 0..15 with one gap; rnd_err=1 because cells 1..4 were in flight.
- start pulsed again while busy, and again in the cycle done=1 -> ignored; a later start in IDLE begins a fresh pass with rnd_err cleared.
- rst_n asserted low while the pipeline holds idx 10..13 -> all outputs 0 immediately; after release, no wr_en appears without a new start.
- rnd_in=0xA5C3F00F with rnd_valid=1 in ISSUE -> r_out=0xC3F00F, rc_out=0xA5, rnd_req=1; in IDLE -> r_out=0, rc_out=0, rnd_req=0.
- NUM_CELLS=4, SBOX_LAT=2 -> wr_idx 0..3 appear two cycles after their issue; done follows after 4+2+1 cycles.
